// File: rtl/conv_line_fifo_if.sv
// Control/data bundle between the convolution controller and the line-delay FIFO.
// The master side drives the FIFO control stream and samples; the slave side is the FIFO.
interface conv_line_fifo_if #(
    parameter int DATA_W     = 16,
    parameter int FIFO_WIDTH = 8
);
    logic                  cfifo_cfg;
    logic [FIFO_WIDTH-1:0] cfifo_cfg_len;
    logic                  cfifo_dvalid;
    logic                  cfifo_load0;
    logic [DATA_W-1:0]     din;
    logic [DATA_W-1:0]     dout;
    logic                  dout_valid;
    logic                  ready;
    logic [FIFO_WIDTH:0]   fill_cnt;
    logic [FIFO_WIDTH-1:0] len_q;

    modport master (
        output cfifo_cfg, cfifo_cfg_len, cfifo_dvalid, cfifo_load0, din,
        input  dout, dout_valid, ready, fill_cnt, len_q
    );

    modport slave (
        input  cfifo_cfg, cfifo_cfg_len, cfifo_dvalid, cfifo_load0, din,
        output dout, dout_valid, ready, fill_cnt, len_q
    );
endinterface

// File: rtl/conv_line_fifo.sv
// Programmable-length line-delay FIFO: every accepted sample re-emerges exactly L pushes later.
// A length code of 0 selects the full 2**FIFO_WIDTH delay.
module conv_line_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    conv_line_fifo_if.slave  bus
);
    localparam int DEPTH = 2 ** FIFO_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [FIFO_WIDTH-1:0] r_wp;
    logic [FIFO_WIDTH-1:0] r_len;
    logic [FIFO_WIDTH:0]   r_fill;
    logic [DATA_W-1:0]     r_dout;
    logic                  r_dout_valid;

    logic                  w_push;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_ready;
    logic [FIFO_WIDTH:0]   w_eff_len;
    logic [FIFO_WIDTH-1:0] w_rd_addr;
    logic [DATA_W-1:0]     w_push_val;

    // A cfg pulse takes priority, so a push in the same cycle is dropped.
    assign w_push     = bus.cfifo_dvalid & ~bus.cfifo_cfg;
    assign w_eff_len  = {(r_len == '0), r_len};
    assign w_rd_addr  = r_wp - r_len;
    assign w_push_val = bus.cfifo_load0 ? '0 : bus.din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.cfifo_cfg) begin
            w_next_state = S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_push && ((r_fill + 1'b1) == w_eff_len)) begin
                        w_next_state = S_RUN;
                    end
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            S_FILL: begin
                w_wr_en = w_push;
                w_ready = 1'b1;
            end
            S_RUN: begin
                w_wr_en = w_push;
                w_rd_en = w_push;
                w_ready = 1'b1;
            end
            default: begin
                w_wr_en = 1'b0;
                w_rd_en = 1'b0;
                w_ready = 1'b0;
            end
        endcase
    end

    // Storage is deliberately not reset; the fill phase guarantees no stale word is read.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wp] <= w_push_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp         <= '0;
            r_len        <= '0;
            r_fill       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (bus.cfifo_cfg) begin
                r_len  <= bus.cfifo_cfg_len;
                r_wp   <= '0;
                r_fill <= '0;
            end else if (w_wr_en) begin
                r_wp <= r_wp + 1'b1;
                if (r_state == S_FILL) begin
                    r_fill <= r_fill + 1'b1;
                end
                // Non-blocking read of the old word gives read-first behaviour at full length.
                if (w_rd_en) begin
                    r_dout       <= r_mem[w_rd_addr];
                    r_dout_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.ready      = w_ready;
    assign bus.fill_cnt   = r_fill;
    assign bus.len_q      = r_len;

endmodule

// File: doc/conv_line_fifo.md
# conv_line_fifo

Programmable-length line-delay FIFO that sits downstream of the convolution controller. It consumes the controller's FIFO control stream: `cfifo_cfg`, `cfifo_cfg_len`, `cfifo_dvalid` and `cfifo_load0`. Each accepted sample is returned exactly L accepted samples later, which produces the row-delayed taps of the convolution window. Zero-padding words are injected on `cfifo_load0`, so no zeros are stored in memory upstream.

## Interface
Parameters:
- DATA_W, 16, sample width.
- FIFO_WIDTH, 8, length/pointer width; storage is 2**FIFO_WIDTH entries (same value as the global `FIFO_WIDTH` define).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfifo_cfg  in  1  one-cycle pulse; latches `cfifo_cfg_len` and restarts the fill.
- cfifo_cfg_len  in  FIFO_WIDTH  delay length L; 0 encodes 2**FIFO_WIDTH.
- cfifo_dvalid  in  1  push qualifier.
- cfifo_load0  in  1  with `cfifo_dvalid`, push zero instead of `din`.
- din  in  DATA_W  sample to push.
- dout  out  DATA_W  delayed sample.
- dout_valid  out  1  `dout` holds a valid delayed sample this cycle.
- ready  out  1  block configured (FILL or RUN).
- fill_cnt  out  FIFO_WIDTH+1  stored samples, saturates at L.
- len_q  out  FIFO_WIDTH  latched length code (readback).

## Operation
- Storage: circular RAM of 2**FIFO_WIDTH words with a write pointer `wp`.
  - Read address = `wp - L` (mod 2**FIFO_WIDTH).
  - Reads are read-first, so when L = 2**FIFO_WIDTH (read address equals `wp`) the old word is returned.
  - RAM is not reset. Unwritten entries are never presented on `dout`.
- Push value = `cfifo_load0 ? 0 : din`. `cfifo_load0` without `cfifo_dvalid` has no effect.
- State machine:
  - IDLE (after reset): pushes are ignored; `ready` = 0. `cfifo_cfg` -> FILL.
  - FILL: each push writes at `wp`, then `wp`++ and `fill_cnt`++. The push that brings `fill_cnt` to L -> RUN. No output in FILL.
  - RUN: each push reads the word at `wp - L`, then writes the new word at `wp`, then `wp`++. The read word appears on `dout` with `dout_valid` = 1 next cycle. `fill_cnt` holds at L.
  - `cfifo_cfg` in any state: `len_q` <= `cfifo_cfg_len`, `wp` <= 0, `fill_cnt` <= 0 -> FILL.
- Simultaneous `cfifo_cfg` and `cfifo_dvalid`: cfg wins and the push is dropped. `dout_valid` is forced 0 in the following cycle.
- Cycles without `cfifo_dvalid` (bubbles) change nothing; `dout_valid` = 0 on those cycles. `dout` holds its last value.
- Arithmetic: pointers wrap modulo 2**FIFO_WIDTH. `fill_cnt` compares against the effective length `{len_q==0, len_q}`, which is FIFO_WIDTH+1 bits wide.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `ready` = 0, `fill_cnt` = 0, `len_q` = 0, state IDLE, `wp` = 0.
- `rst` mid-operation: all of the above in the next cycle; any in-flight output is discarded.
- Latency and throughput:
  - Throughput: one push per cycle, no backpressure.
  - Push n (counting from 1 after cfg) produces output on the cycle after push n+L, carrying sample n.
  - The first `dout_valid` occurs on the cycle after push L+1.
- `ready` rises the cycle after `cfifo_cfg` and stays high until `rst`.
- `fill_cnt` updates the cycle after each FILL push.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Unconfigured pushes: reset, then push 10 samples with no cfg -> `ready` = 0, `dout_valid` never rises, `fill_cnt` = 0.
- Basic delay: cfg L = 3, push 1..6 back-to-back -> `fill_cnt` reads 1, 2, 3, 3…; `dout_valid` pulses on the cycles after pushes 4, 5, 6 with `dout` = 1, 2, 3.
- Zero injection with bubbles: cfg L = 2; push 5, then (`cfifo_load0`, `din` = 0xAAAA), 7, 8, with 2 idle cycles between pushes -> outputs are 5 then 0, each `dout_valid` exactly one cycle, none during bubbles.
- Maximum length with FIFO_WIDTH = 8: cfg L = 0 (256), push 0..299 -> first `dout_valid` after push 257 carries 0; output k = k-256 up to 43. Checks read-first at the full-wrap address.
- Reconfiguration: running at L = 4, assert cfg L = 2 together with `cfifo_dvalid` -> that push is dropped and `fill_cnt` = 0. The next 2 pushes give no output; the 3rd push outputs the first post-cfg sample.
- Reset mid-run: L = 3 in RUN, pulse `rst` -> next cycle all outputs equal their reset values, state IDLE; pushes are ignored until a new cfg.
